// File: rtl/legal_instr_gen.sv
// Stream source of legal MIPS-I instruction words driven by a 32-bit LFSR.
// Define LEGAL_INSTR_GEN_ILLEGAL_EN to inject an illegal opcode every 16th word.
module legal_instr_gen #(
    parameter logic [31:0] SEED    = 32'hACE1_2024,
    parameter int          COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] count,
    input  logic               ready,
    output logic               valid,
    output logic [31:0]        instruction,
    output logic [COUNT_W-1:0] index,
    output logic               busy,
`ifdef LEGAL_INSTR_GEN_ILLEGAL_EN
    output logic               illegal,
`endif
    output logic               done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [1:0]         state;
    logic [31:0]        lfsr;
    logic [31:0]        lfsr_nxt;
    logic [COUNT_W-1:0] idx;
    logic [COUNT_W-1:0] cnt;

    assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lfsr  <= SEED_EFF;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt <= count;
                    if (count != '0) begin
                        state <= RUN;
                        lfsr  <= SEED_EFF;
                        idx   <= '0;
                    end else begin
                        state <= DONE;
                    end
                end
                RUN: if (ready) begin
                    if (idx == cnt - COUNT_W'(1)) begin
                        state <= DONE;
                    end else begin
                        idx  <= idx + COUNT_W'(1);
                        lfsr <= lfsr_nxt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign valid = (state == RUN);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign index = idx;

    logic [2:0] cls;
    logic [2:0] s;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    logic [5:0] fn;
    logic [31:0] word;

    assign cls = lfsr[2:0];
    assign s   = lfsr[7:5];

    // Defaults keep imm/target equal to the raw lfsr bits for I/J formats.
    always_comb begin
        op = 6'h00;
        rs = lfsr[25:21];
        rt = lfsr[20:16];
        rd = lfsr[15:11];
        sa = lfsr[10:6];
        fn = lfsr[5:0];
        case (cls)
            3'd0: begin
                sa = '0;
                case (s)
                    3'd0:    fn = 6'h21;
                    3'd1:    fn = 6'h24;
                    3'd2:    fn = 6'h25;
                    3'd3:    fn = 6'h26;
                    3'd4:    fn = 6'h27;
                    3'd5:    fn = 6'h2a;
                    3'd6:    fn = 6'h2b;
                    default: fn = 6'h23;
                endcase
            end
            3'd1: begin
                rs = '0;
                case (s[1:0])
                    2'd2:    fn = 6'h02;
                    2'd3:    fn = 6'h03;
                    default: fn = 6'h00;
                endcase
            end
            3'd2: begin
                case (s)
                    3'd1:    op = 6'h0a;
                    3'd2:    op = 6'h0b;
                    3'd3:    op = 6'h0c;
                    3'd4:    op = 6'h0d;
                    3'd5:    op = 6'h0e;
                    3'd6: begin
                        op = 6'h0f;
                        rs = '0;
                    end
                    default: op = 6'h09;
                endcase
            end
            3'd3: begin
                case (s)
                    3'd0:    op = 6'h20;
                    3'd1:    op = 6'h21;
                    3'd2:    op = 6'h22;
                    3'd4:    op = 6'h24;
                    3'd5:    op = 6'h25;
                    3'd6:    op = 6'h26;
                    default: op = 6'h23;
                endcase
            end
            3'd4: begin
                case (s[1:0])
                    2'd0:    op = 6'h28;
                    2'd1:    op = 6'h29;
                    default: op = 6'h2b;
                endcase
            end
            3'd5: begin
                if (!s[2]) begin
                    op = {4'b0001, s[1:0]};
                    if (s[1]) rt = '0;
                end else begin
                    op = 6'h01;
                    rt = {s[1], 3'b000, s[0]};
                end
            end
            3'd6: begin
                rd = '0;
                sa = '0;
                fn = {4'b0110, s[1:0]};
            end
            default: begin
                case (s)
                    3'd0: op = 6'h02;
                    3'd1: op = 6'h03;
                    3'd2: begin
                        rt = '0; rd = '0; sa = '0; fn = 6'h08;
                    end
                    3'd3: begin
                        rt = '0; sa = '0; fn = 6'h09;
                    end
                    3'd4: begin
                        rs = '0; rt = '0; sa = '0; fn = 6'h10;
                    end
                    3'd5: begin
                        rs = '0; rt = '0; sa = '0; fn = 6'h12;
                    end
                    3'd6: begin
                        rt = '0; rd = '0; sa = '0; fn = 6'h11;
                    end
                    default: begin
                        rt = '0; rd = '0; sa = '0; fn = 6'h13;
                    end
                endcase
            end
        endcase
    end

    assign word = {op, rs, rt, rd, sa, fn};

`ifdef LEGAL_INSTR_GEN_ILLEGAL_EN
    assign illegal     = (idx[3:0] == 4'hF);
    assign instruction = illegal ? {6'b111111, lfsr[25:0]} : word;
`else
    assign instruction = word;
`endif

endmodule

// File: tb/tb_legal_instr_gen.sv
// Bench for legal_instr_gen: two seeds share one stimulus stream and are
// compared against a word-level model and an independent legality checker.
module tb_legal_instr_gen;

    logic        clk = 0;
    logic        reset;
    logic        start;
    logic [15:0] count;
    logic        ready;
    logic        v   [2];
    logic [31:0] ins [2];
    logic [15:0] idx [2];
    logic        bsy [2];
    logic        dn  [2];
`ifdef LEGAL_INSTR_GEN_ILLEGAL_EN
    logic        ill [2];
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] seeds [2];

    always #5 clk = ~clk;

    legal_instr_gen #(.SEED(32'h0), .COUNT_W(16)) u0 (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .ready(ready), .valid(v[0]), .instruction(ins[0]),
        .index(idx[0]), .busy(bsy[0]),
`ifdef LEGAL_INSTR_GEN_ILLEGAL_EN
        .illegal(ill[0]),
`endif
        .done(dn[0])
    );

    legal_instr_gen #(.COUNT_W(16)) u1 (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .ready(ready), .valid(v[1]), .instruction(ins[1]),
        .index(idx[1]), .busy(bsy[1]),
`ifdef LEGAL_INSTR_GEN_ILLEGAL_EN
        .illegal(ill[1]),
`endif
        .done(dn[1])
    );

    localparam int ALU_FN [8] = '{'h21, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b, 'h23};
    localparam int SHF_FN [4] = '{'h00, 'h00, 'h02, 'h03};
    localparam int IALU_OP [8] = '{'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e, 'h0f, 'h09};
    localparam int LD_OP [8] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h23};
    localparam int ST_OP [4] = '{'h28, 'h29, 'h2b, 'h2b};
    localparam int RIMM_RT [4] = '{0, 1, 16, 17};

    function automatic logic [31:0] step(logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] pack(int op, int rs, int rt, int rd, int sa, int fn);
        return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16)
             | (32'(rd) << 11) | (32'(sa) << 6) | 32'(fn);
    endfunction

    function automatic logic [31:0] enc(logic [31:0] l);
        int c, s, rs, rt, rd, sa;
        c  = int'(l[2:0]);
        s  = int'(l[7:5]);
        rs = int'(l[25:21]);
        rt = int'(l[20:16]);
        rd = int'(l[15:11]);
        sa = int'(l[10:6]);
        case (c)
            0: return pack(0, rs, rt, rd, 0, ALU_FN[s]);
            1: return pack(0, 0, rt, rd, sa, SHF_FN[s % 4]);
            2: return (32'(IALU_OP[s]) << 26) | (32'(s == 6 ? 0 : rs) << 21)
                    | (32'(rt) << 16) | {16'h0, l[15:0]};
            3: return (32'(LD_OP[s]) << 26) | {6'h0, l[25:0]};
            4: return (32'(ST_OP[s % 4]) << 26) | {6'h0, l[25:0]};
            5: begin
                if (s < 4)
                    return (32'(4 + s) << 26) | (32'(rs) << 21)
                         | (32'(s >= 2 ? 0 : rt) << 16) | {16'h0, l[15:0]};
                return (32'(1) << 26) | (32'(rs) << 21)
                     | (32'(RIMM_RT[s - 4]) << 16) | {16'h0, l[15:0]};
            end
            6: return pack(0, rs, rt, 0, 0, 'h18 + (s % 4));
            default: begin
                case (s)
                    0: return {6'h02, l[25:0]};
                    1: return {6'h03, l[25:0]};
                    2: return pack(0, rs, 0, 0, 0, 'h08);
                    3: return pack(0, rs, 0, rd, 0, 'h09);
                    4: return pack(0, 0, 0, rd, 0, 'h10);
                    5: return pack(0, 0, 0, rd, 0, 'h12);
                    6: return pack(0, rs, 0, 0, 0, 'h11);
                    default: return pack(0, rs, 0, 0, 0, 'h13);
                endcase
            end
        endcase
    endfunction

    function automatic bit legal(logic [31:0] w);
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd, sa;
        op = w[31:26]; rs = w[25:21]; rt = w[20:16];
        rd = w[15:11]; sa = w[10:6];  fn = w[5:0];
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03: return rs == 0;
                    6'h08: return rt == 0 && rd == 0 && sa == 0;
                    6'h09: return rt == 0 && sa == 0;
                    6'h10, 6'h12: return rs == 0 && rt == 0 && sa == 0;
                    6'h11, 6'h13: return rt == 0 && rd == 0 && sa == 0;
                    6'h18, 6'h19, 6'h1a, 6'h1b: return rd == 0 && sa == 0;
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b:
                        return sa == 0;
                    default: return 0;
                endcase
            end
            6'h01: return rt == 0 || rt == 1 || rt == 16 || rt == 17;
            6'h02, 6'h03, 6'h04, 6'h05: return 1;
            6'h06, 6'h07: return rt == 0;
            6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: return 1;
            6'h0f: return rs == 0;
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: return 1;
            6'h28, 6'h29, 6'h2b: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit inj(int k);
`ifdef LEGAL_INSTR_GEN_ILLEGAL_EN
        return (k % 16) == 15;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] expw(logic [31:0] l, int k);
        if (inj(k)) return {6'b111111, l[25:0]};
        return enc(l);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_valid"}, 32'(v[i]), 0);
            chk({tag, "_busy"}, 32'(bsy[i]), 0);
            chk({tag, "_done"}, 32'(dn[i]), 0);
        end
    endtask

    task automatic run_stream(int n, int stall, bit rnd, int abort_at);
        logic [31:0] ml [2];
        int k, st, cyc;
        ml = seeds;
        k = 0; st = 0; cyc = 0;
        @(negedge clk);
        start = 1;
        count = 16'(n);
        @(negedge clk);
        start = 0;
        if (n == 0) begin
            for (int i = 0; i < 2; i++) begin
                chk("zero_done", 32'(dn[i]), 1);
                chk("zero_valid", 32'(v[i]), 0);
                chk("zero_busy", 32'(bsy[i]), 0);
            end
            @(negedge clk);
            chk_quiet("zero_after");
            return;
        end
        while (k < n && cyc < 20 * n + 50) begin
            for (int i = 0; i < 2; i++) begin
                chk("run_valid", 32'(v[i]), 1);
                chk("run_busy", 32'(bsy[i]), 1);
                chk("run_done", 32'(dn[i]), 0);
                chk("index", 32'(idx[i]), 32'(k));
                chk("word", ins[i], expw(ml[i], k));
                chk("legal", 32'(legal(ins[i])), 32'(!inj(k)));
`ifdef LEGAL_INSTR_GEN_ILLEGAL_EN
                chk("illegal", 32'(ill[i]), 32'(inj(k)));
`endif
            end
            if (k == 0) chk("seed0_word0", ins[0], 32'h0000_0000);
            if (k == 1) chk("seed0_word1", ins[0], 32'h8020_0003);
            if (k == abort_at) begin
                #2 reset = 1;
                #1;
                for (int i = 0; i < 2; i++)
                    chk("abort_index", 32'(idx[i]), 0);
                chk_quiet("abort");
                ready = 0;
                @(negedge clk);
                reset = 0;
                return;
            end
            if (k == 0 && st < stall) begin
                ready = 0;
                st++;
            end else begin
                ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            end
            if (rnd) begin
                start = 1'($urandom_range(1, 0));
                count = 16'($urandom_range(5, 0));
            end
            if (ready) begin
                k++;
                for (int i = 0; i < 2; i++) ml[i] = step(ml[i]);
            end
            cyc++;
            @(negedge clk);
        end
        start = 0;
        ready = 0;
        if (k < n) begin
            chk("timeout", 32'(k), 32'(n));
            return;
        end
        for (int i = 0; i < 2; i++) begin
            chk("end_done", 32'(dn[i]), 1);
            chk("end_valid", 32'(v[i]), 0);
            chk("end_busy", 32'(bsy[i]), 0);
        end
        @(negedge clk);
        chk_quiet("idle");
        for (int i = 0; i < 2; i++)
            chk("idle_index_hold", 32'(idx[i]), 32'(n - 1));
    endtask

    typedef struct {
        int n;
        int stall;
        bit rnd;
        int abort_at;
    } vec_t;

    vec_t tbl [7];

    initial begin
        seeds[0] = 32'h0000_0001;
        seeds[1] = 32'hACE1_2024;
        tbl[0] = '{2, 0, 1'b0, -1};
        tbl[1] = '{0, 0, 1'b0, -1};
        tbl[2] = '{3, 5, 1'b0, -1};
        tbl[3] = '{1000, 0, 1'b1, -1};
        tbl[4] = '{100, 0, 1'b0, 37};
        tbl[5] = '{1, 0, 1'b0, -1};
        tbl[6] = '{32, 2, 1'b1, -1};

        reset = 1;
        start = 0;
        count = 0;
        ready = 0;
        #3;
        for (int i = 0; i < 2; i++)
            chk("reset_index", 32'(idx[i]), 0);
        chk_quiet("reset");
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk_quiet("post_reset");

        for (int t = 0; t < 7; t++)
            run_stream(tbl[t].n, tbl[t].stall, tbl[t].rnd, tbl[t].abort_at);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/legal_instr_gen.md
Name: legal_instr_gen

Overview:
- Synthesizable stimulus source that emits a stream of MIPS-I instruction words.
- Every word is one the CPU's instruction-legality checker accepts.
- Used by the CPU-level bench, and by a self-test harness, to drive the fetch path through a valid/ready handshake.
- Instruction content is a pure function of a 32-bit LFSR state, so streams are reproducible from SEED.

Parameters:
- SEED, 32'hACE1_2024, initial LFSR state; a value of 0 is replaced by 32'h0000_0001.
- COUNT_W, 16, width of the count and index fields.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a stream; sampled only in IDLE.
- count  input  COUNT_W  number of words to emit; sampled with start.
- ready  input  1  consumer accepts the current word.
- valid  output  1  instruction is valid.
- instruction  output  32  generated instruction word.
- index  output  COUNT_W  position of the current word within the stream, starting at 0.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the stream completes.

Behaviour:
- Reset values: state=IDLE, lfsr=SEED (0 mapped to 1), valid=0, index=0, busy=0, done=0.
- Reset mid-stream aborts the stream immediately; no partial handshake is completed.
- LFSR step: next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0).
- The LFSR steps only on an accepted word (valid && ready).

State machine:
- IDLE, start=1, count!=0: go to RUN; reload lfsr from SEED; index=0.
- IDLE, start=1, count==0: go to DONE; no word is emitted.
- start is ignored outside IDLE.
- RUN: valid=1, busy=1. While valid && !ready, instruction and index stay stable.
- RUN, on accept: if index==count_latched-1, go to DONE; otherwise index+1 and step the LFSR.
- DONE: done=1 and valid=0 for exactly one cycle, then IDLE.
- index and lfsr hold their values in IDLE.

Encoding (combinational from the current lfsr):
- Class select: cls = lfsr[2:0]; sub-select: s = lfsr[7:5].
- Default fields: rs=lfsr[25:21], rt=lfsr[20:16], rd=lfsr[15:11], imm=lfsr[15:0], target=lfsr[25:0].
- cls 0, R-ALU: op 0, sa=0; funct by s = ADDU, AND, OR, XOR, NOR, SLT, SLTU, SUBU.
- cls 1, shift: op 0, rs=0, sa=lfsr[10:6]; funct by s[1:0] = SLL, SLL, SRL, SRA.
- cls 2, I-ALU: op by s = ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, ADDIU. LUI forces rs=0.
- cls 3, load: op by s = LB, LH, LWL, LW, LBU, LHU, LWR, LW.
- cls 4, store: op by s[1:0] = SB, SH, SW, SW.
- cls 5, branch: s = BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL.
  - BLEZ/BGTZ force rt=0.
  - The last four use op 000001 with rt = 00000, 00001, 10000, 10001 respectively.
- cls 6, mult/div: op 0, rd=0, sa=0; funct by s[1:0] = MULT, MULTU, DIV, DIVU.
- cls 7: s = J, JAL, JR, JALR, MFHI, MFLO, MTHI, MTLO.
  - JR: rt=rd=sa=0.
  - JALR: rt=0, sa=0.
  - MFHI/MFLO: rs=rt=sa=0.
  - MTHI/MTLO: rt=rd=sa=0.
- Every emitted word must pass the legality checker; there are no exceptions without the optional feature.

Optional Feature:
- Macro: LEGAL_INSTR_GEN_ILLEGAL_EN.
- Defined:
  - Adds output port illegal (1 bit).
  - When index[3:0]==4'hF, instruction = {6'b111111, lfsr[25:0]} and illegal=1. This is rejected by the legality checker.
  - All other words are unchanged; illegal=0.
- Not defined: no illegal port; the stream is always legal.

Test Plan:
- SEED=0, count=2, ready=1:
  - word0 = 32'h0000_0000 (SLL, lfsr=1), index=0.
  - word1 = 32'h8020_0003 (LB rs=1 imm=3), index=1.
  - done pulses one cycle after the second accept; then IDLE with valid=0.
- count=0 with start: valid never rises; done pulses once; busy stays 0.
- Backpressure, ready=0 for 5 cycles at index 0: instruction and index are held stable; the LFSR does not advance. After ready=1 the stream resumes identical to the no-stall run.
- count=1000, random ready, every word fed to the legality checker: Verify=1 for all 1000 words; index runs 0..999 with no gaps.
- Reset asserted mid-RUN at index 37: valid, busy, done and index all 0 immediately. A following start with the same SEED reproduces word0 bit-exact.
- With LEGAL_INSTR_GEN_ILLEGAL_EN, count=32: illegal=1 and opcode=6'b111111 at index 15 and 31 only; the checker rejects exactly those 2 words.
